bist_signature_analyzer: RTL and testbench
==========================================

BIST_SIGNATURE_ANALYZER -- requirements
Module: bist_signature_analyzer

Interface
REQ-001 Parameter SIG_W, default 16: MISR/signature width in bits.
REQ-002 Parameter POLY, default 16'h1021: MISR feedback polynomial.
REQ-003 Parameter SEED, default 16'hFFFF: MISR value loaded on start.
REQ-004 Parameter GOLDEN, default 16'h0000: expected final signature.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit, used only when BIST_TIMEOUT_EN is defined.
REQ-006 clock  input  1  single clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle pulse from the BIST controller that begins a compaction run.
REQ-009 scan_valid  input  1  scan_out carries a valid scan-chain response this cycle.
REQ-010 scan_last  input  1  qualifies the final valid response of the run; ignored unless scan_valid=1.
REQ-011 scan_out  input  2  scan-chain response bits, matching the 2-bit test_out chain.
REQ-012 busy  output  1  high in the COMPRESS and COMPARE states.
REQ-013 bist_end  output  1  run complete; held until the next accepted start or reset.
REQ-014 pass_nfail  output  1  1 means the final signature equals GOLDEN; valid only while bist_end=1.
REQ-015 timeout  output  1  run aborted by the watchdog; tied to 0 when BIST_TIMEOUT_EN is undefined.
REQ-016 signature  output  SIG_W  current MISR contents.

Function
REQ-017 The block SHALL implement the FSM IDLE, COMPRESS, COMPARE, DONE.
REQ-018 IDLE or DONE, start=1: the block SHALL load the MISR with SEED, clear bist_end, pass_nfail and timeout, and go to COMPRESS on the next edge.
REQ-019 start in COMPRESS or COMPARE SHALL be ignored.
REQ-020 In IDLE and DONE, scan_valid SHALL be ignored.
REQ-021 On a start edge, scan_valid SHALL be ignored for that cycle.
REQ-022 COMPRESS, scan_valid=1: the MISR SHALL update as next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ {0, scan_out}, with scan_out XORed into bits [1:0].
REQ-023 COMPRESS, scan_valid=0: the MISR SHALL hold its value.
REQ-024 COMPRESS, scan_valid=1 and scan_last=1: the block SHALL apply the update and go to COMPARE.
REQ-025 COMPARE: the block SHALL register pass_nfail = (signature == GOLDEN) and set bist_end=1, both visible one cycle after COMPARE is entered, then go to DONE.
REQ-026 Latency from the last-response edge to bist_end=1 SHALL be 2 clock edges.
REQ-027 DONE SHALL hold signature, pass_nfail and bist_end stable until an accepted start.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force: state IDLE, signature 0, busy 0, bist_end 0, pass_nfail 0, timeout 0, watchdog count 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no bist_end pulse.
REQ-030 After reset is released, the block SHALL wait in IDLE for start.

Configuration
REQ-031 With BIST_TIMEOUT_EN defined, a counter SHALL clear on an accepted start and increment each COMPRESS cycle.
REQ-032 With BIST_TIMEOUT_EN defined, if the count reaches TIMEOUT_CYCLES-1 in COMPRESS without a scan_valid&scan_last, the block SHALL go to DONE with timeout=1, pass_nfail=0, bist_end=1.
REQ-033 With BIST_TIMEOUT_EN defined, if scan_last arrives on that same cycle, the last response SHALL win and the normal COMPARE path SHALL be taken.
REQ-034 With BIST_TIMEOUT_EN undefined, no counter logic SHALL be generated, timeout SHALL be constant 0, and COMPRESS SHALL wait indefinitely.

Structure
REQ-035 Shared package bist_pkg SHALL hold the FSM state enum, the default POLY and SEED constants, and the signature width default.
REQ-036 The MISR datapath SHALL be a sub-module bist_misr (load, enable, 2-bit data in, SIG_W state out).
REQ-037 FSM, compare and watchdog logic SHALL reside in the top module.

Verification
REQ-038 Single step: reset release, start, then one scan_valid=1, scan_last=1, scan_out=2'b01 -> signature=16'hEFDE, then bist_end=1 two edges later, pass_nfail=0 (GOLDEN=16'h0000).
REQ-039 Golden match: GOLDEN set to 16'hEFDE, same stimulus -> pass_nfail=1, bist_end=1, busy=0.
REQ-040 Gaps: scan_valid toggled 1,0,0,1 with data 01,xx,xx,01 -> identical to a back-to-back two-response run; signature holds during the gaps.
REQ-041 Mid-run disturbances: start pulsed mid-COMPRESS -> ignored, signature unchanged; reset=0 mid-COMPRESS -> all outputs 0 immediately, no bist_end.
REQ-042 Timeout (BIST_TIMEOUT_EN defined, TIMEOUT_CYCLES=8): start, no scan_last -> timeout=1, bist_end=1, pass_nfail=0 after 8 COMPRESS cycles; with the macro undefined, timeout stays 0 and bist_end stays 0.
REQ-043 Restart from DONE: start -> bist_end and pass_nfail clear next edge and signature=16'hFFFF.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST signature analyzer.
// Holds the FSM state enum and the MISR width/polynomial/seed defaults.
package bist_pkg;

  localparam int SIG_W_DEF = 16;

  localparam logic [SIG_W_DEF-1:0] POLY_DEF = 16'h1021;
  localparam logic [SIG_W_DEF-1:0] SEED_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPRESS,
    ST_COMPARE,
    ST_DONE
  } bist_state_e;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register folding a 2-bit scan response
// into an SIG_W-bit signature; load takes priority over enable.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [1:0]       data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] fb;
  logic [SIG_W-1:0] nxt;

  assign fb  = sig[SIG_W-1] ? POLY : '0;
  assign nxt = (sig << 1) ^ fb
             ^ {{(SIG_W-2){1'b0}}, data};

  // Seed on load, shift-and-fold on enable, otherwise hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig <= '0;
    end else if (load) begin
      sig <= SEED;
    end else if (enable) begin
      sig <= nxt;
    end
  end

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST response compactor: MISR run control, golden compare, watchdog.
// Define BIST_TIMEOUT_EN to build the COMPRESS-state watchdog.
module bist_signature_analyzer
  import bist_pkg::*;
#(
  parameter int               SIG_W          = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY           = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED           = SIG_W'(SEED_DEF),
  parameter logic [SIG_W-1:0] GOLDEN         = '0,
  parameter int               TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             scan_valid,
  input  logic             scan_last,
  input  logic [1:0]       scan_out,
  output logic             busy,
  output logic             bist_end,
  output logic             pass_nfail,
  output logic             timeout,
  output logic [SIG_W-1:0] signature
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  bist_state_e state;
  logic        idle_like;
  logic        accept;
  logic        misr_en;
  logic        last_hit;

  assign idle_like = (state == ST_IDLE)
                  || (state == ST_DONE);
  assign accept    = start && idle_like;
  assign misr_en   = (state == ST_COMPRESS)
                  && scan_valid;
  assign last_hit  = misr_en && scan_last;

`ifdef BIST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             wd_hit;

  assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  bist_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .enable (misr_en),
    .data   (scan_out),
    .sig    (signature)
  );

  // Run sequencing with registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      bist_end   <= 1'b0;
      pass_nfail <= 1'b0;
`ifdef BIST_TIMEOUT_EN
      timeout    <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_COMPRESS;
            busy       <= 1'b1;
            bist_end   <= 1'b0;
            pass_nfail <= 1'b0;
`ifdef BIST_TIMEOUT_EN
            timeout    <= 1'b0;
            wd_cnt     <= '0;
`endif
          end
        end
        ST_COMPRESS: begin
          if (last_hit) begin
            state <= ST_COMPARE;
`ifdef BIST_TIMEOUT_EN
          end else if (wd_hit) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            bist_end   <= 1'b1;
            pass_nfail <= 1'b0;
            timeout    <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        ST_COMPARE: begin
          state      <= ST_DONE;
          busy       <= 1'b0;
          bist_end   <= 1'b1;
          pass_nfail <= (signature == GOLDEN);
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer.
// Two instances: GOLDEN=0 (fail path) and GOLDEN=EFDE (pass path).
module tb_bist_signature_analyzer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        scan_valid = 1'b0;
  logic        scan_last = 1'b0;
  logic [1:0]  scan_out = 2'b00;

  logic        busy, bist_end, pass_nfail, timeout;
  logic [15:0] signature;
  logic        g_busy, g_end, g_pass, g_to;
  logic [15:0] g_sig;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bist_signature_analyzer #(
    .GOLDEN         (16'h0000),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .scan_valid (scan_valid),
    .scan_last  (scan_last),
    .scan_out   (scan_out),
    .busy       (busy),
    .bist_end   (bist_end),
    .pass_nfail (pass_nfail),
    .timeout    (timeout),
    .signature  (signature)
  );

  bist_signature_analyzer #(
    .GOLDEN         (16'hEFDE),
    .TIMEOUT_CYCLES (8)
  ) dut_g (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .scan_valid (scan_valid),
    .scan_last  (scan_last),
    .scan_out   (scan_out),
    .busy       (g_busy),
    .bist_end   (g_end),
    .pass_nfail (g_pass),
    .timeout    (g_to),
    .signature  (g_sig)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic scan(input logic v, input logic l,
                      input logic [1:0] d);
    scan_valid = v;
    scan_last  = l;
    scan_out   = d;
    tick();
    scan_valid = 1'b0;
    scan_last  = 1'b0;
    scan_out   = 2'b00;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, bist_end, pass_nfail, timeout, signature} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %b/%h want 0000/0000",
               {busy, bist_end, pass_nfail, timeout}, signature);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy, bist_end, signature} !== 18'h0) begin
      n_bad++;
      $display("FAIL idle_wait: got %b%b/%h want 00/0000",
               busy, bist_end, signature);
    end
  endtask

  task automatic test_single_step();
    do_start();
    n_cmp++;
    if (signature !== 16'hFFFF || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL seed_load: got %h busy %b want ffff busy 1",
               signature, busy);
    end
    scan(1'b1, 1'b1, 2'b01);
    n_cmp++;
    if (signature !== 16'hEFDE || bist_end !== 1'b0) begin
      n_bad++;
      $display("FAIL step_sig: got %h end %b want efde end 0",
               signature, bist_end);
    end
    tick();
    n_cmp++;
    if ({bist_end, pass_nfail, busy, timeout} !== 4'b1000) begin
      n_bad++;
      $display("FAIL step_end: got %b want 1000",
               {bist_end, pass_nfail, busy, timeout});
    end
    tick();
    tick();
    n_cmp++;
    if (signature !== 16'hEFDE || bist_end !== 1'b1) begin
      n_bad++;
      $display("FAIL done_hold: got %h end %b want efde end 1",
               signature, bist_end);
    end
  endtask

  task automatic test_golden();
    n_cmp++;
    if ({g_end, g_pass, g_busy} !== 3'b110 || g_sig !== 16'hEFDE) begin
      n_bad++;
      $display("FAIL golden: got %b/%h want 110/efde",
               {g_end, g_pass, g_busy}, g_sig);
    end
  endtask

  task automatic test_restart();
    do_start();
    n_cmp++;
    if ({g_end, g_pass, g_busy} !== 3'b001 || g_sig !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL restart: got %b/%h want 001/ffff",
               {g_end, g_pass, g_busy}, g_sig);
    end
  endtask

  task automatic test_gaps();
    scan(1'b1, 1'b0, 2'b01);
    scan(1'b0, 1'b0, 2'b11);
    n_cmp++;
    if (signature !== 16'hEFDE) begin
      n_bad++;
      $display("FAIL gap_hold: got %h want efde", signature);
    end
    scan(1'b0, 1'b1, 2'b10);
    scan(1'b1, 1'b1, 2'b01);
    n_cmp++;
    if (signature !== 16'hCF9C || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_sig: got %h busy %b want cf9c busy 1",
               signature, busy);
    end
    tick();
    n_cmp++;
    if ({bist_end, pass_nfail, g_pass} !== 3'b100) begin
      n_bad++;
      $display("FAIL gap_end: got %b want 100",
               {bist_end, pass_nfail, g_pass});
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    scan(1'b1, 1'b0, 2'b01);
    scan(1'b1, 1'b1, 2'b01);
    n_cmp++;
    if (signature !== 16'hCF9C) begin
      n_bad++;
      $display("FAIL b2b_sig: got %h want cf9c", signature);
    end
    tick();
    scan(1'b1, 1'b1, 2'b11);
    scan(1'b1, 1'b0, 2'b10);
    n_cmp++;
    if (signature !== 16'hCF9C || bist_end !== 1'b1) begin
      n_bad++;
      $display("FAIL done_scan_ign: got %h end %b want cf9c end 1",
               signature, bist_end);
    end
  endtask

  task automatic test_start_scan_same_edge();
    start      = 1'b1;
    scan_valid = 1'b1;
    scan_last  = 1'b1;
    scan_out   = 2'b11;
    tick();
    start      = 1'b0;
    scan_valid = 1'b0;
    scan_last  = 1'b0;
    n_cmp++;
    if (signature !== 16'hFFFF || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_edge_scan: got %h busy %b want ffff busy 1",
               signature, busy);
    end
  endtask

  task automatic test_mid_start();
    scan(1'b1, 1'b0, 2'b01);
    do_start();
    n_cmp++;
    if (signature !== 16'hEFDE || {busy, bist_end} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_start: got %h %b want efde 10",
               signature, {busy, bist_end});
    end
    start = 1'b1;
    scan(1'b1, 1'b0, 2'b01);
    start = 1'b0;
    n_cmp++;
    if (signature !== 16'hCF9C || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_start_scan: got %h busy %b want cf9c busy 1",
               signature, busy);
    end
  endtask

  task automatic test_mid_reset();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, bist_end, pass_nfail, timeout, signature} !== 20'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got %b/%h want 0000/0000",
               {busy, bist_end, pass_nfail, timeout}, signature);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy, bist_end, signature} !== 18'h0) begin
      n_bad++;
      $display("FAIL post_reset: got %b/%h want 00/0000",
               {busy, bist_end}, signature);
    end
  endtask

  task automatic test_timeout();
    do_start();
    repeat (7) tick();
`ifdef BIST_TIMEOUT_EN
    n_cmp++;
    if ({timeout, bist_end, busy} !== 3'b001) begin
      n_bad++;
      $display("FAIL to_early: got %b want 001",
               {timeout, bist_end, busy});
    end
    tick();
    n_cmp++;
    if ({timeout, bist_end, pass_nfail, busy} !== 4'b1100) begin
      n_bad++;
      $display("FAIL to_fire: got %b want 1100",
               {timeout, bist_end, pass_nfail, busy});
    end
    do_start();
    n_cmp++;
    if ({timeout, bist_end} !== 2'b00) begin
      n_bad++;
      $display("FAIL to_clear: got %b want 00", {timeout, bist_end});
    end
    repeat (7) tick();
    scan(1'b1, 1'b1, 2'b01);
    tick();
    n_cmp++;
    if ({timeout, bist_end, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL to_last_wins: got %b want 010",
               {timeout, bist_end, busy});
    end
`else
    repeat (20) tick();
    n_cmp++;
    if ({timeout, bist_end, busy} !== 3'b001) begin
      n_bad++;
      $display("FAIL no_timeout: got %b want 001",
               {timeout, bist_end, busy});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_golden();
    test_restart();
    test_gaps();
    test_back_to_back();
    test_start_scan_same_edge();
    test_mid_start();
    test_mid_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
